// File: rtl/impulse_monitor.sv
// impulse_monitor
//   AXI-Stream sink that checks a periodic impulse train: exactly one
//   PULSE_VAL every PERIOD beats, zeros on every other beat. It hunts for the
//   first impulse, confirms LOCK_CNT impulses in a row at the expected spacing,
//   then reports lock, the phase at which lock was acquired, and counts
//   violations seen while locked.
//
// Ports
//   clk            in   clock, all logic on the rising edge
//   rst            in   synchronous reset, active-high
//   s_axis_tdata   in   [WIDTH-1:0] stream data
//   s_axis_tvalid  in   stream valid
//   s_axis_tready  out  stream ready, low only while rst is high
//   locked         out  impulse train tracked and confirmed
//   err            out  sticky, a violation occurred while locked
//   err_cnt        out  [CNT_W-1:0] violations while locked, saturating
//   impulse_cnt    out  [CNT_W-1:0] good impulses while locked, wrapping
//   pulse_phase    out  [$clog2(PERIOD)-1:0] beat index at which lock began
module impulse_monitor #(
  parameter int             WIDTH     = 16,
  parameter int             PERIOD    = 64,
  parameter logic [WIDTH-1:0] PULSE_VAL = WIDTH'(1),
  parameter int             LOCK_CNT  = 3,
  parameter int             CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic                      locked,
  output logic                      err,
  output logic [CNT_W-1:0]          err_cnt,
  output logic [CNT_W-1:0]          impulse_cnt,
  output logic [$clog2(PERIOD)-1:0] pulse_phase
);

  localparam int PH_W   = $clog2(PERIOD);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam logic [PH_W-1:0]   LAST_IDX = PH_W'(PERIOD - 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    SEEK    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [PH_W-1:0]   beat_idx_reg;
  logic [PH_W-1:0]   ph_reg;
  logic [GOOD_W-1:0] good_reg;
  logic [PH_W-1:0]   pulse_phase_reg;
  logic              locked_reg;
  logic              err_reg;
  logic [CNT_W-1:0]  err_cnt_reg;
  logic [CNT_W-1:0]  impulse_cnt_reg;

  logic              beat;
  logic              is_pulse;
  logic              slot;
  logic              slot_ok;
  logic [GOOD_W-1:0] good_inc;

  // Action strobes decoded from state and the current beat
  logic seek_hit;
  logic acq_good;
  logic acq_fail;
  logic lock_gain;
  logic locked_good;
  logic locked_bad;

  assign beat     = s_axis_tvalid & s_axis_tready;
  assign is_pulse = (s_axis_tdata == PULSE_VAL);
  assign slot     = (ph_reg == '0);
  // In the impulse slot only PULSE_VAL is legal; everywhere else only zero.
  assign slot_ok  = slot ? is_pulse : (s_axis_tdata == '0);
  assign good_inc = good_reg + GOOD_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= SEEK;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (beat) begin
      case (state_reg)
        SEEK: begin
          if (is_pulse) begin
            state_next = (LOCK_CNT == 1) ? LOCKED : ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (!slot_ok) begin
            state_next = SEEK;
          end else if (slot && (good_inc == GOOD_MAX)) begin
            state_next = LOCKED;
          end
        end
        LOCKED: begin
          if (!slot_ok) begin
            state_next = SEEK;
          end
        end
        default: state_next = SEEK;
      endcase
    end
  end

  // Output / action decode
  always_comb begin
    s_axis_tready = ~rst;
    seek_hit      = 1'b0;
    acq_good      = 1'b0;
    acq_fail      = 1'b0;
    lock_gain     = 1'b0;
    locked_good   = 1'b0;
    locked_bad    = 1'b0;
    if (beat) begin
      case (state_reg)
        SEEK:    seek_hit = is_pulse;
        ACQUIRE: begin
          acq_good  = slot && slot_ok;
          acq_fail  = !slot_ok;
          lock_gain = slot && slot_ok && (good_inc == GOOD_MAX);
        end
        LOCKED: begin
          locked_good = slot && slot_ok;
          locked_bad  = !slot_ok;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers; everything advances only on accepted beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_idx_reg    <= '0;
      ph_reg          <= '0;
      good_reg        <= '0;
      pulse_phase_reg <= '0;
      locked_reg      <= 1'b0;
      err_reg         <= 1'b0;
      err_cnt_reg     <= '0;
      impulse_cnt_reg <= '0;
    end else if (beat) begin
      beat_idx_reg <= (beat_idx_reg == LAST_IDX) ? '0 : beat_idx_reg + PH_W'(1);

      if (seek_hit) begin
        // The hit beat itself is slot 0, so the following beat is slot 1.
        pulse_phase_reg <= beat_idx_reg;
        ph_reg          <= PH_W'(1);
        good_reg        <= GOOD_W'(1);
        locked_reg      <= (LOCK_CNT == 1);
      end else begin
        ph_reg <= (ph_reg == LAST_IDX) ? '0 : ph_reg + PH_W'(1);
      end

      if (acq_good) begin
        good_reg <= good_inc;
      end
      if (acq_fail) begin
        good_reg <= '0;
      end
      if (lock_gain) begin
        locked_reg <= 1'b1;
      end
      if (locked_good) begin
        impulse_cnt_reg <= impulse_cnt_reg + CNT_W'(1);
      end
      if (locked_bad) begin
        locked_reg <= 1'b0;
        err_reg    <= 1'b1;
        good_reg   <= '0;
        if (err_cnt_reg != '1) begin
          err_cnt_reg <= err_cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  assign locked      = locked_reg;
  assign err         = err_reg;
  assign err_cnt     = err_cnt_reg;
  assign impulse_cnt = impulse_cnt_reg;
  assign pulse_phase = pulse_phase_reg;

endmodule
